// File: rtl/fp_norm_round_pipe_pkg.sv
// rtl/fp_norm_round_pipe_pkg.sv - shared types and constant-word helpers for the normalise/round pipeline
package fpNormPkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Magnitude words exclude the sign bit and are right-aligned in 64 bits.
  function automatic logic [63:0] fp_inf_mag(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_max_mag(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_norm_round_pipe_lzc.sv
// rtl/fp_norm_round_pipe_lzc.sv - combinational leading-zero counter, returns W for an all-zero input
module fp_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         data_i,
  output logic [$clog2(W+1)-1:0] count_o
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) count_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// rtl/fp_norm_round_pipe.sv - three-stage normalise, round and flag pipeline with valid/ready backpressure
module fp_norm_round_pipe
  import fpNormPkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_special,
  input  logic [EXP_W+MAN_W:0]   in_special_word,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic                   in_carry,
  input  logic [MAN_W+8:0]       in_mant,
  input  logic                   in_sticky,
  input  logic [1:0]             in_rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [2:0]             out_flags
);

  localparam int ALIGN_W = MAN_W + 9;
  localparam int RES_W   = 1 + EXP_W + MAN_W;
  localparam int LZC_W   = $clog2(ALIGN_W + 1);
  localparam int EW1     = EXP_W + 1;
  localparam logic [63:0]    INF_MAG = fp_inf_mag(EXP_W, MAN_W);
  localparam logic [63:0]    MAX_MAG = fp_max_mag(EXP_W, MAN_W);
  localparam logic [EXP_W:0] EXP_OVF = {1'b0, {EXP_W{1'b1}}};

  typedef struct packed {
    logic               special;
    logic [RES_W-1:0]   sword;
    logic               sign;
    rnd_mode_t          rnd;
    logic [EXP_W-1:0]   exp;
    logic               carry;
    logic [ALIGN_W-1:0] mant;
    logic               sticky;
    logic [LZC_W-1:0]   shift;
  } s1_t;

  typedef struct packed {
    logic             special;
    logic [RES_W-1:0] sword;
    logic             sign;
    rnd_mode_t        rnd;
    logic             zero;
    logic [EXP_W:0]   exp;
    logic [MAN_W:0]   sig;
    logic             g;
    logic             r;
    logic             s;
  } s2_t;

  logic v1_q, v2_q, v3_q;
  logic load1, load2, load3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [RES_W-1:0] res_d, res_q;
  fp_flags_t        flags_d, flags_q;

  // Each stage refills when empty or when its occupant moves on this cycle.
  assign load3    = !v3_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  assign out_valid  = v3_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

  logic [LZC_W-1:0] lzc;
  logic [EXP_W-1:0] exp_m1;

  fp_lzc #(.W(ALIGN_W)) u_lzc (
    .data_i  (in_mant),
    .count_o (lzc)
  );

  always_comb begin
    exp_m1         = (in_exp == '0) ? '0 : in_exp - EXP_W'(1);
    s1_d.special   = in_special;
    s1_d.sword     = in_special_word;
    s1_d.sign      = in_sign;
    s1_d.rnd       = rnd_mode_t'(in_rnd);
    s1_d.exp       = in_exp;
    s1_d.carry     = in_carry;
    s1_d.mant      = in_mant;
    s1_d.sticky    = in_sticky;
    if (in_carry)                     s1_d.shift = '0;
    else if (32'(exp_m1) < 32'(lzc))  s1_d.shift = LZC_W'(exp_m1);
    else                              s1_d.shift = lzc;
  end

  logic [ALIGN_W-1:0] m2;

  always_comb begin
    if (s1_q.carry) m2 = {1'b1, s1_q.mant[ALIGN_W-1:1]};
    else            m2 = s1_q.mant << s1_q.shift;
    s2_d.special = s1_q.special;
    s2_d.sword   = s1_q.sword;
    s2_d.sign    = s1_q.sign;
    s2_d.rnd     = s1_q.rnd;
    s2_d.zero    = !s1_q.carry && (s1_q.mant == '0) && !s1_q.sticky;
    s2_d.sig     = m2[ALIGN_W-1:8];
    s2_d.g       = m2[7];
    s2_d.r       = m2[6];
    // The carry right-shift pushes mant[0] out of the fold window.
    s2_d.s       = (|m2[5:0]) | s1_q.sticky | (s1_q.carry & s1_q.mant[0]);
    if (s1_q.carry)           s2_d.exp = {1'b0, s1_q.exp} + EW1'(1);
    else if (m2[ALIGN_W-1])   s2_d.exp = {1'b0, s1_q.exp} - EW1'(s1_q.shift);
    else                      s2_d.exp = '0;
  end

  logic             lost;
  logic             rup;
  logic             bump;
  logic             ovf;
  logic             to_inf;
  logic [MAN_W+1:0] sum3;
  logic [EXP_W:0]   exp3;

  always_comb begin
    lost = s2_q.g | s2_q.r | s2_q.s;
    case (s2_q.rnd)
      RND_RNE: rup = s2_q.g & (s2_q.r | s2_q.s | s2_q.sig[0]);
      RND_RTZ: rup = 1'b0;
      RND_RUP: rup = !s2_q.sign & lost;
      default: rup = s2_q.sign & lost;
    endcase
    sum3 = {1'b0, s2_q.sig} + {{(MAN_W + 1){1'b0}}, rup};
    // Exponent steps on significand overflow or a subnormal rounding up to the hidden bit.
    bump   = sum3[MAN_W+1] | (!s2_q.sig[MAN_W] & sum3[MAN_W]);
    exp3   = s2_q.exp + {{EXP_W{1'b0}}, bump};
    ovf    = exp3 >= EXP_OVF;
    to_inf = (s2_q.rnd == RND_RNE) || (s2_q.rnd == RND_RUP && !s2_q.sign) ||
             (s2_q.rnd == RND_RDN && s2_q.sign);

    flags_d.overflow  = ovf;
    flags_d.inexact   = lost | ovf;
    flags_d.underflow = (lost | ovf) & (s2_q.exp == '0);

    if (s2_q.special) begin
      res_d   = s2_q.sword;
      flags_d = '0;
    end else if (s2_q.zero) begin
      res_d   = {(s2_q.rnd == RND_RDN), {(RES_W - 1){1'b0}}};
      flags_d = '0;
    end else if (ovf) begin
      res_d = {s2_q.sign, to_inf ? INF_MAG[RES_W-2:0] : MAX_MAG[RES_W-2:0]};
    end else begin
      res_d = {s2_q.sign, exp3[EXP_W-1:0], sum3[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (load1) begin
        v1_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (load2) begin
        v2_q <= v1_q;
        if (v1_q) s2_q <= s2_d;
      end
      if (load3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb/tb_fp_norm_round_pipe.sv - vector table, backpressure/reset sequences and randomized scoreboard run
module tb_fp_norm_round_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_special;
  logic [31:0] in_special_word;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_carry;
  logic [31:0] in_mant;
  logic        in_sticky;
  logic [1:0]  in_rnd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  fp_norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_special      (in_special),
    .in_special_word (in_special_word),
    .in_sign         (in_sign),
    .in_exp          (in_exp),
    .in_carry        (in_carry),
    .in_mant         (in_mant),
    .in_sticky       (in_sticky),
    .in_rnd          (in_rnd),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_flags       (out_flags)
  );

  typedef struct {
    logic        special;
    logic [31:0] sword;
    logic        sign;
    logic [7:0]  exp;
    logic        carry;
    logic [31:0] mant;
    logic        sticky;
    logic [1:0]  rnd;
    logic [31:0] exp_res;
    logic [2:0]  exp_fl;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic sp, input logic [31:0] sw, input logic sg,
                              input logic [7:0] e, input logic c, input logic [31:0] m,
                              input logic st, input logic [1:0] rm,
                              input logic [31:0] er, input logic [2:0] ef);
    vec_t v;
    v.special = sp; v.sword = sw; v.sign = sg; v.exp = e; v.carry = c;
    v.mant = m; v.sticky = st; v.rnd = rm; v.exp_res = er; v.exp_fl = ef;
    return v;
  endfunction

  // Reference: treat {carry,mant} as an exact integer scaled by in_exp, place the
  // result LSB at the target exponent, and round the discarded remainder directly.
  function automatic void ref_model(input vec_t v, output logic [31:0] res, output logic [2:0] fl);
    longint x, kept, rem, half, sig;
    int     msb, et, eq, lsb, field;
    bit     tiny, inex, gt, tie, up, ovf, to_inf;
    res = '0;
    fl  = '0;
    if (v.special) begin
      res = v.sword;
      return;
    end
    x = longint'({v.carry, v.mant});
    if (x == 0 && !v.sticky) begin
      res = {(v.rnd == 2'd3), 31'd0};
      return;
    end
    msb = -1;
    for (int i = 0; i < 33; i++) if (x[i]) msb = i;
    et   = (msb < 0) ? 0 : int'(v.exp) + msb - 31;
    tiny = (et < 1);
    eq   = tiny ? 1 : et;
    lsb  = 8 + eq - int'(v.exp);
    if (lsb <= 0) begin
      kept = x << (-lsb);
      rem  = 0;
      half = 1;
    end else begin
      kept = x >> lsb;
      rem  = x & ((64'sd1 << lsb) - 1);
      half = 64'sd1 << (lsb - 1);
    end
    inex = (rem != 0) || v.sticky;
    gt   = (rem > half) || (rem == half && v.sticky);
    tie  = (rem == half) && !v.sticky && (lsb > 0);
    case (v.rnd)
      2'd0:    up = gt || (tie && kept[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !v.sign && inex;
      default: up = v.sign && inex;
    endcase
    sig = kept + (up ? 64'sd1 : 64'sd0);
    if (sig >= (64'sd1 << 24)) begin
      sig = sig >> 1;
      eq++;
    end
    field = (sig >= (64'sd1 << 23)) ? eq : 0;
    ovf   = (field >= 255);
    if (ovf) begin
      to_inf = (v.rnd == 2'd0) || (v.rnd == 2'd2 && !v.sign) || (v.rnd == 2'd3 && v.sign);
      res = to_inf ? {v.sign, 8'hFF, 23'd0} : {v.sign, 8'hFE, 23'h7FFFFF};
    end else begin
      res = {v.sign, 8'(field), 23'(sig)};
    end
    fl = {ovf, (inex || ovf) && tiny, inex || ovf};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   sel;
    v.special = ($urandom_range(0, 15) == 0);
    v.sword   = $urandom;
    v.sign    = 1'($urandom_range(0, 1));
    sel       = $urandom_range(0, 3);
    v.exp     = (sel == 0) ? 8'($urandom_range(1, 12)) :
                (sel == 1) ? 8'($urandom_range(240, 254)) : 8'($urandom_range(1, 254));
    v.carry   = ($urandom_range(0, 3) == 0);
    v.mant    = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 9) == 0) v.mant = '0;
    v.sticky  = 1'($urandom_range(0, 1));
    v.rnd     = 2'($urandom_range(0, 3));
    v.exp_res = '0;
    v.exp_fl  = '0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_special      = v.special;
    in_special_word = v.sword;
    in_sign         = v.sign;
    in_exp          = v.exp;
    in_carry        = v.carry;
    in_mant         = v.mant;
    in_sticky       = v.sticky;
    in_rnd          = v.rnd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 3);
    chk($sformatf("vec%0d_valid", idx), out_valid, 1);
    chk($sformatf("vec%0d_result", idx), out_result, v.exp_res);
    chk($sformatf("vec%0d_flags", idx), out_flags, v.exp_fl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[20];
  vec_t        bp[5];
  vec_t        cur;
  logic [34:0] q[$];
  logic [34:0] e;
  logic [31:0] r;
  logic [2:0]  f;
  logic [31:0] save_res;
  logic [2:0]  save_fl;
  int          sent, acc, got, ghost;
  bit          took, stall;

  initial begin
    tbl[0]  = mk(0, 0, 0, 8'h7F, 0, 32'h80000000, 0, 2'd0, 32'h3F800000, 3'b000);
    tbl[1]  = mk(0, 0, 0, 8'h7F, 1, 32'h00000000, 0, 2'd0, 32'h40000000, 3'b000);
    tbl[2]  = mk(0, 0, 0, 8'h7F, 0, 32'h80000180, 0, 2'd0, 32'h3F800002, 3'b001);
    tbl[3]  = mk(0, 0, 0, 8'h7F, 0, 32'h80000180, 0, 2'd1, 32'h3F800001, 3'b001);
    tbl[4]  = mk(0, 0, 0, 8'hFE, 1, 32'h00000000, 0, 2'd0, 32'h7F800000, 3'b101);
    tbl[5]  = mk(0, 0, 0, 8'hFE, 1, 32'h00000000, 0, 2'd1, 32'h7F7FFFFF, 3'b101);
    tbl[6]  = mk(0, 0, 1, 8'hFE, 1, 32'h00000000, 0, 2'd2, 32'hFF7FFFFF, 3'b101);
    tbl[7]  = mk(0, 0, 0, 8'h01, 0, 32'h40000000, 0, 2'd0, 32'h00400000, 3'b000);
    tbl[8]  = mk(0, 0, 0, 8'h01, 0, 32'h40000040, 0, 2'd0, 32'h00400000, 3'b011);
    tbl[9]  = mk(0, 0, 0, 8'h7F, 0, 32'h00000000, 0, 2'd3, 32'h80000000, 3'b000);
    tbl[10] = mk(0, 0, 1, 8'h7F, 0, 32'h00000000, 0, 2'd0, 32'h00000000, 3'b000);
    tbl[11] = mk(1, 32'h7FC00000, 0, 8'hFE, 1, 32'h0, 1, 2'd0, 32'h7FC00000, 3'b000);
    tbl[12] = mk(0, 0, 0, 8'h01, 0, 32'h7FFFFF80, 0, 2'd0, 32'h00800000, 3'b011);
    tbl[13] = mk(0, 0, 0, 8'h7F, 0, 32'hFFFFFF80, 0, 2'd0, 32'h40000000, 3'b001);
    tbl[14] = mk(0, 0, 1, 8'h7F, 0, 32'h80000001, 0, 2'd3, 32'hBF800001, 3'b001);
    tbl[15] = mk(0, 0, 0, 8'h7F, 0, 32'h00000100, 0, 2'd0, 32'h34000000, 3'b000);
    tbl[16] = mk(0, 0, 0, 8'h05, 0, 32'h00000100, 0, 2'd0, 32'h00000010, 3'b000);
    tbl[17] = mk(0, 0, 0, 8'hFE, 1, 32'h00000000, 0, 2'd3, 32'h7F7FFFFF, 3'b101);
    tbl[18] = mk(0, 0, 0, 8'h7F, 0, 32'h00000000, 1, 2'd2, 32'h00000001, 3'b011);
    tbl[19] = mk(0, 0, 0, 8'h7F, 0, 32'h80000080, 0, 2'd0, 32'h3F800000, 3'b001);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_flags", out_flags, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 20; i++) run_vec(tbl[i], i);

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_table", out_valid, 0);

    // Backpressure: five back-to-back offers, consumer stalled for six cycles.
    for (int i = 0; i < 5; i++) begin
      bp[i] = rand_vec();
      bp[i].special = 1'b0;
    end
    q.delete();
    out_ready = 1'b0;
    sent = 0; acc = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk); #1;
      if (c == 6) out_ready = 1'b1;
      if (sent < 5) begin
        drive(bp[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 3) chk("bp_in_ready_full", in_ready, 0);
      if (c == 5) begin
        chk("bp_accepts_while_stalled", acc, 3);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_no_output_while_stalled", got, 0);
      end
      if (in_valid && in_ready) begin
        ref_model(bp[sent], r, f);
        q.push_back({f, r});
        sent++;
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL bp_extra_output: got %h expected none", out_result);
        end else begin
          e = q.pop_front();
          chk($sformatf("bp_out%0d_result", got), out_result, e[31:0]);
          chk($sformatf("bp_out%0d_flags", got), out_flags, e[34:32]);
        end
        got++;
      end
    end
    chk("bp_output_count", got, 5);
    chk("bp_queue_empty", q.size(), 0);

    // Mid-stream reset with a full, stalled pipeline.
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(bp[c]);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_out_valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_result", out_result, 0);
    chk("rst_async_out_flags", out_flags, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    ghost = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk("rst_no_ghost_outputs", ghost, 0);

    // Randomized traffic with random stalls against the reference model.
    q.delete();
    took  = 1'b0;
    stall = 1'b0;
    cur   = rand_vec();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!in_valid || took) begin
        if (c < 1400 && $urandom_range(0, 3) != 0) begin
          cur = rand_vec();
          drive(cur);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (c >= 1400) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall) begin
        chk("rand_hold_valid", out_valid, 1);
        chk("rand_hold_result", out_result, save_res);
        chk("rand_hold_flags", out_flags, save_fl);
      end
      took = in_valid && in_ready;
      if (took) begin
        ref_model(cur, r, f);
        q.push_back({f, r});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL rand_extra_output: got %h expected none", out_result);
        end else begin
          e = q.pop_front();
          chk("rand_result", out_result, e[31:0]);
          chk("rand_flags", out_flags, e[34:32]);
        end
      end
      stall    = out_valid && !out_ready;
      save_res = out_result;
      save_fl  = out_flags;
    end
    chk("rand_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
